fetch_decode_pipe: RTL and testbench
====================================

# fetch_decode_pipe

Fetch-side responder to the pipeline hazard locks. It owns the PC register, the synchronous instruction-memory request, and the IF/ID pipeline register. It obeys the active-low `PCLocker`/`IF_IDLocker` stall requests without losing the fetch already in flight, using a one-entry skid register. It also flushes on a taken branch from the ALU stage and presents the instruction to the decoder.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction word driven when IF/ID is empty (`addi x0,x0,0`).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset (one clock; polarity/synchronicity fixed).
- `PCLocker` input 1: 0 = hold PC and issue no new fetch; 1 = run.
- `IF_IDLocker` input 1: 0 = hold IF/ID contents; 1 = IF/ID may advance.
- `branchTaken` input 1: redirect request from ALU stage.
- `branchTarget` input 32: redirect address; bits [1:0] ignored (forced 0).
- `imemReq` output 1: fetch request this cycle.
- `imemAddr` output 32: fetch address (= PC register).
- `imemRdata` input 32: instruction for the request issued the previous cycle (fixed 1-cycle latency).
- `ifIdValid` output 1: IF/ID holds a live instruction.
- `ifIdPc` output 32: PC of IF/ID instruction.
- `ifIdInstr` output 32: IF/ID instruction; `NOP_INSTR` when `ifIdValid`=0.
- `stallCount` output 32: present only with `FETCH_STALL_CNT_EN`.

## Operation
- State: PC register, `pendValid`/`pendPc` (request issued last cycle), skid register (`skidValid`/`skidPc`/`skidInstr`), IF/ID register.
- Issue: `imemReq` = `PCLocker` & not in reset. On issue, PC += 4, `pendValid`←1, `pendPc`←PC. With no issue, PC holds and `pendValid`←0.
- Response: when `pendValid`=1, `imemRdata` is the instruction for `pendPc`.
- IF/ID update when `IF_IDLocker`=1, in priority order:
  - `skidValid` → load skid; clear skid.
  - Response present → load response.
  - Otherwise → `ifIdValid`←0, `ifIdInstr`←`NOP_INSTR`.
- When `IF_IDLocker`=0: IF/ID holds. A response arriving that cycle goes to skid.
- Skid and response collision (`skidValid`=1 and response arrives, IF/ID locked): cannot occur, because PC issue is gated by `PCLocker`. The team's hazard unit always drops the two locks together. The implementation asserts on this condition in simulation only.
- Flush: `branchTaken`=1 takes priority over every lock.
  - PC←`branchTarget`&~3; no request issued that cycle.
  - `pendValid`←0, which discards any response due next cycle.
  - `skidValid`←0.
  - `ifIdValid`←0, `ifIdInstr`←`NOP_INSTR`.
- Reset (asynchronous, at any point mid-operation): PC←`RESET_PC`, `imemReq`=0, `pendValid`=0, `skidValid`=0, `ifIdValid`=0, `ifIdPc`=0, `ifIdInstr`=`NOP_INSTR`, `stallCount`=0.
- PC wrap-around: 32'hFFFF_FFFC + 4 → 0. No trap.

## Timing
- Cycle 0 = first rising edge with `rst_n`=1. `imemReq`=1, `imemAddr`=`RESET_PC` during cycle 0.
- `imemRdata` is valid in cycle 1. `ifIdValid`=1 with that instruction from cycle 2, so fetch-to-IF/ID latency is 2 cycles.
- Unstalled throughput: one instruction per cycle; `ifIdPc` increments by 4 each cycle.
- Lock asserted in cycle N:
  - No request in cycle N.
  - The response to cycle N-1's request lands in skid at the end of cycle N.
  - IF/ID is frozen from cycle N+1.
- Lock released in cycle M:
  - The skid instruction enters IF/ID at the end of M.
  - The new request in M returns in M+1 and enters IF/ID at the end of M+1.
  - No bubble and no duplicate.
- Flush in cycle B: the first request to the target is issued in cycle B+1. Its instruction is in IF/ID from cycle B+3, and `ifIdValid`=0 in cycles B+1 and B+2.
- Flush and locks low in the same cycle: flush wins; after the flush, the locks apply from cycle B+1.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stallCount` port exists.
  - Increments by 1 (saturating at 32'hFFFF_FFFF) on every cycle with `IF_IDLocker`=0 and `ifIdValid`=1.
  - Reset to 0 by `rst_n`; not cleared by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release with `RESET_PC`=0, memory returning addr+32'h100 → `ifIdValid` rises in cycle 2; `ifIdPc` = 0, 4, 8…; `ifIdInstr` = 32'h100, 32'h104…
- Both locks 0 for 3 cycles starting at cycle 5 →
  - `imemReq`=0 for 3 cycles.
  - IF/ID frozen at `ifIdPc`=12.
  - After release, `ifIdPc` continues 16, 20 with no gap and no repeat.
- `branchTaken`=1, `branchTarget`=32'h0000_0203 in cycle 6 →
  - `imemAddr`=32'h200 in cycle 7.
  - `ifIdValid`=0 in cycles 7–8, `ifIdInstr`=32'h13.
  - `ifIdPc`=32'h200 in cycle 9.
- `branchTaken`=1 while both locks are 0 → skid discarded; behaves exactly as the previous case.
- Set PC to 32'hFFFF_FFFC via branch → next `imemAddr`=0.
- `rst_n` pulsed low mid-stall with skid full → all outputs take their reset values immediately, and the fetch sequence restarts from `RESET_PC`. With `FETCH_STALL_CNT_EN`, `stallCount`=3 after the 3-cycle stall and 0 after reset.

Source files
------------

// File: rtl/fetch_decode_pipe_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the IF/ID register view.
// master = fetch stage driving the requests and IF/ID, slave = memory/decoder side.
interface fetch_decode_pipe_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        ifIdValid;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdInstr;

  modport master (
    output imemReq, imemAddr, ifIdValid, ifIdPc, ifIdInstr,
    input  imemRdata
  );

  modport slave (
    input  imemReq, imemAddr, ifIdValid, ifIdPc, ifIdInstr,
    output imemRdata
  );
endinterface

// File: rtl/fetch_decode_pipe.sv
// PC, 1-cycle instruction fetch and IF/ID register with a one-entry skid for hazard stalls.
// Optional stall counter port enabled by defining FETCH_STALL_CNT_EN.
module fetch_decode_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCLocker,
  input  logic               IF_IDLocker,
  input  logic               branchTaken,
  input  logic [31:0]        branchTarget,
  fetch_decode_pipe_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]        stallCount
`endif
);

  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        issue;

  // A redirect cycle never fetches: the PC is being replaced at this edge.
  assign issue        = PCLocker & ~branchTaken;
  assign bus.imemReq  = issue & rst_n;
  assign bus.imemAddr = pc;
  assign bus.ifIdValid = if_id_valid;
  assign bus.ifIdPc    = if_id_pc;
  assign bus.ifIdInstr = if_id_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_pc     <= '0;
      skid_valid  <= 1'b0;
      skid_pc     <= '0;
      skid_instr  <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (branchTaken) begin
      pc          <= branchTarget & ~32'd3;
      pend_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else begin
      if (issue) begin
        pc      <= pc + 32'd4;
        pend_pc <= pc;
      end
      pend_valid <= issue;

      if (IF_IDLocker) begin
        if (skid_valid) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= skid_pc;
          if_id_instr <= skid_instr;
          skid_valid  <= 1'b0;
        end else if (pend_valid) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= pend_pc;
          if_id_instr <= bus.imemRdata;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end else if (pend_valid) begin
        // The in-flight response would be lost while IF/ID is frozen, so park it.
        skid_valid <= 1'b1;
        skid_pc    <= pend_pc;
        skid_instr <= bus.imemRdata;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (!IF_IDLocker && if_id_valid && (stallCount != '1)) begin
      stallCount <= stallCount + 32'd1;
    end
  end
`endif

  // The hazard unit drops both locks together, so a live skid never meets a response.
  always_ff @(posedge clk) begin
    if (rst_n && !branchTaken) begin
      assert (!(skid_valid && pend_valid));
    end
  end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed self-checking bench for fetch_decode_pipe: fetch stream, lock stall, flush, wrap, async reset.
module tb_fetch_decode_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCLocker;
  logic        IF_IDLocker;
  logic        branchTaken;
  logic [31:0] branchTarget;
  int          cyc;
  int          n_checks = 0;
  int          n_fail = 0;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stallCount;
`endif

  fetch_decode_pipe_if bus ();

  fetch_decode_pipe #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCLocker    (PCLocker),
    .IF_IDLocker (IF_IDLocker),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .bus         (bus.master)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stallCount  (stallCount)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory: word at addr is addr + 0x100, one cycle after the request.
  always @(posedge clk) begin
    if (bus.imemReq) bus.imemRdata <= bus.imemAddr + 32'h100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_values();
    chk("rst_imemReq", {31'd0, bus.imemReq}, 32'd0);
    chk("rst_imemAddr", bus.imemAddr, 32'h0);
    chk("rst_ifIdValid", {31'd0, bus.ifIdValid}, 32'd0);
    chk("rst_ifIdPc", bus.ifIdPc, 32'h0);
    chk("rst_ifIdInstr", bus.ifIdInstr, 32'h13);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stallCount", stallCount, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    PCLocker = 1'b1;
    IF_IDLocker = 1'b1;
    branchTaken = 1'b0;
    branchTarget = '0;
    @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Checks for cycles B+1..B+4 after a flush to 0x203 in cycle B=6; leaves cyc at 11.
  task automatic flush_checks(input string tag);
    @(negedge clk);
    chk({tag, "_addr7"}, bus.imemAddr, 32'h200);
    chk({tag, "_req7"}, {31'd0, bus.imemReq}, 32'd1);
    chk({tag, "_valid7"}, {31'd0, bus.ifIdValid}, 32'd0);
    chk({tag, "_instr7"}, bus.ifIdInstr, 32'h13);
    next_cycle();
    @(negedge clk);
    chk({tag, "_valid8"}, {31'd0, bus.ifIdValid}, 32'd0);
    chk({tag, "_instr8"}, bus.ifIdInstr, 32'h13);
    next_cycle();
    @(negedge clk);
    chk({tag, "_valid9"}, {31'd0, bus.ifIdValid}, 32'd1);
    chk({tag, "_pc9"}, bus.ifIdPc, 32'h200);
    chk({tag, "_instr9"}, bus.ifIdInstr, 32'h300);
    next_cycle();
    @(negedge clk);
    chk({tag, "_pc10"}, bus.ifIdPc, 32'h204);
    chk({tag, "_instr10"}, bus.ifIdInstr, 32'h304);
    next_cycle();
  endtask

  initial begin
    // Plain fetch stream after reset release.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("c0_req", {31'd0, bus.imemReq}, 32'd1);
        chk("c0_addr", bus.imemAddr, 32'h0);
      end
      chk("stream_valid", {31'd0, bus.ifIdValid}, (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        chk("stream_pc", bus.ifIdPc, 32'(4 * (c - 2)));
        chk("stream_instr", bus.ifIdInstr, 32'(4 * (c - 2)) + 32'h100);
      end else begin
        chk("stream_nop", bus.ifIdInstr, 32'h13);
      end
      next_cycle();
    end

    // Both locks low in cycles 5..7.
    PCLocker = 1'b0;
    IF_IDLocker = 1'b0;
    for (int c = 5; c < 8; c++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, bus.imemReq}, 32'd0);
      chk("stall_pc", bus.ifIdPc, 32'd12);
      chk("stall_instr", bus.ifIdInstr, 32'h10C);
      next_cycle();
    end
    PCLocker = 1'b1;
    IF_IDLocker = 1'b1;
    @(negedge clk);
    chk("rel_pc8", bus.ifIdPc, 32'd12);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_count3", stallCount, 32'd3);
`endif
    next_cycle();
    for (int c = 9; c < 12; c++) begin
      @(negedge clk);
      chk("rel_valid", {31'd0, bus.ifIdValid}, 32'd1);
      chk("rel_pc", bus.ifIdPc, 32'(4 * (c - 5)));
      chk("rel_instr", bus.ifIdInstr, 32'(4 * (c - 5)) + 32'h100);
      next_cycle();
    end

    // Flush in cycle 6, no locks.
    do_reset();
    while (cyc < 6) next_cycle();
    branchTaken = 1'b1;
    branchTarget = 32'h0000_0203;
    @(negedge clk);
    chk("br_req6", {31'd0, bus.imemReq}, 32'd0);
    chk("br_pc6", bus.ifIdPc, 32'd16);
    next_cycle();
    branchTaken = 1'b0;
    flush_checks("flush");

    // Flush in cycle 6 while both locks are low with a full skid.
    do_reset();
    while (cyc < 5) next_cycle();
    PCLocker = 1'b0;
    IF_IDLocker = 1'b0;
    next_cycle();
    branchTaken = 1'b1;
    branchTarget = 32'h0000_0203;
    @(negedge clk);
    chk("lkbr_req6", {31'd0, bus.imemReq}, 32'd0);
    next_cycle();
    branchTaken = 1'b0;
    PCLocker = 1'b1;
    IF_IDLocker = 1'b1;
    flush_checks("lockflush");

    // PC wrap-around via a branch to the top word (low bits ignored).
    branchTaken = 1'b1;
    branchTarget = 32'hFFFF_FFFF;
    next_cycle();
    branchTaken = 1'b0;
    @(negedge clk);
    chk("wrap_addr_top", bus.imemAddr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_addr_zero", bus.imemAddr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("wrap_pc_top", bus.ifIdPc, 32'hFFFF_FFFC);
    chk("wrap_instr_top", bus.ifIdInstr, 32'h0000_00FC);
    next_cycle();
    @(negedge clk);
    chk("wrap_pc_zero", bus.ifIdPc, 32'h0);
    chk("wrap_instr_zero", bus.ifIdInstr, 32'h100);

    // Asynchronous reset in the middle of a stall with the skid occupied.
    do_reset();
    while (cyc < 5) next_cycle();
    PCLocker = 1'b0;
    IF_IDLocker = 1'b0;
    while (cyc < 8) next_cycle();
    @(negedge clk);
    chk("mid_pc", bus.ifIdPc, 32'd12);
`ifdef FETCH_STALL_CNT_EN
    chk("mid_stall_count", stallCount, 32'd3);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    PCLocker = 1'b1;
    IF_IDLocker = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("restart_valid", {31'd0, bus.ifIdValid}, (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk("restart_pc", bus.ifIdPc, 32'(4 * (c - 2)));
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no end of test, expected end before 20000");
    $fatal(1, "timeout");
  end
endmodule
